// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback and drives datapath selects and strobes.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lsb,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mem_we,
    output logic       rf_we,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_ctrl,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       retire,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I,
        ALU_WB, BRANCH, JAL, JALR, JALR_LINK, LUI, HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t state_q, state_d;
    logic   halted_q, halted_d, illegal_q, illegal_d, taken;
    logic   pc_we_s, ir_we_s, mem_we_s, rf_we_s, retire_s;

    // funct3[0] inverts the sense; funct3[2] selects the SLT-style compare
    assign taken = funct3[2] ? (alu_lsb ^ funct3[0]) : (!funct3[1] && (alu_zero ^ funct3[0]));

    // The immediate is reused after DECODE (address, OP-IMM, JALR, LUI), so decode it always
    assign imm_src = (opcode == OP_STORE)                      ? 3'b001 :
                     (opcode == OP_BRANCH)                     ? 3'b010 :
                     (opcode == OP_LUI || opcode == OP_AUIPC)  ? 3'b011 :
                     (opcode == OP_JAL)                        ? 3'b100 : 3'b000;

    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        pc_we_s    = 1'b0;
        ir_we_s    = 1'b0;
        mem_we_s   = 1'b0;
        rf_we_s    = 1'b0;
        retire_s   = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = 2'b00;
        result_src = 2'b00;
        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_we_s    = mem_ready;
                pc_we_s    = mem_ready;
                state_d    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_R:              state_d = EXEC_R;
                    OP_IMM:            state_d = EXEC_I;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = ALU_WB;
                    OP_BRANCH: begin
                        state_d   = (funct3[2:1] == 2'b01) ? HALT : BRANCH;
                        halted_d  = halted_q || (funct3[2:1] == 2'b01);
                        illegal_d = illegal_q || (funct3[2:1] == 2'b01);
                    end
                    OP_FENCE: begin
                        state_d  = FETCH;
                        retire_s = 1'b1;
                    end
                    OP_SYSTEM: begin
                        state_d   = HALT;
                        halted_d  = 1'b1;
                        illegal_d = funct3 != 3'b000;
                    end
                    default: begin
                        state_d   = HALT;
                        halted_d  = 1'b1;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = opcode[5] ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                adr_src = 1'b1;
                state_d = mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                result_src = 2'b01;
                rf_we_s    = 1'b1;
                retire_s   = 1'b1;
                state_d    = FETCH;
            end
            MEM_WRITE: begin
                adr_src  = 1'b1;
                mem_we_s = mem_ready;
                retire_s = mem_ready;
                state_d  = mem_ready ? FETCH : MEM_WRITE;
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                alu_ctrl  = 2'b10;
                state_d   = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = 2'b10;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                rf_we_s  = 1'b1;
                retire_s = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_ctrl  = 2'b01;
                pc_we_s   = taken;
                retire_s  = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                pc_we_s   = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = ALU_WB;
            end
            JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_we_s    = 1'b1;
                state_d    = JALR_LINK;
            end
            JALR_LINK: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = ALU_WB;
            end
            LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = ALU_WB;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign pc_we   = pc_we_s && !rst;
    assign ir_we   = ir_we_s && !rst;
    assign mem_we  = mem_we_s && !rst;
    assign rf_we   = rf_we_s && !rst;
    assign retire  = retire_s && !rst;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign state   = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized checks of the control FSM against
// a per-instruction timeline model (cycle count, strobe cycles, stall insertion).
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       alu_zero = 1'b0, alu_lsb = 1'b0, mem_ready = 1'b0;
    logic       pc_we, ir_we, mem_we, rf_we, adr_src, retire, halted, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_ctrl, result_src;
    logic [2:0] imm_src;
    logic [3:0] state;
    int checks = 0, errors = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .alu_zero(alu_zero),
        .alu_lsb(alu_lsb), .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we),
        .mem_we(mem_we), .rf_we(rf_we), .adr_src(adr_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .result_src(result_src),
        .imm_src(imm_src), .retire(retire), .halted(halted), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] strobes();
        return 8'({ir_we, pc_we, mem_we, rf_we, retire});
    endfunction

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk({nm, " strobes in reset"}, strobes(), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk({nm, " halted after reset"}, 8'(halted), 8'd0);
        chk({nm, " illegal after reset"}, 8'(illegal), 8'd0);
        chk({nm, " strobes idle fetch"}, strobes(), 8'd0);
    endtask

    task automatic partial(input string nm, input logic [6:0] op, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            opcode = op;
            funct3 = 3'b000;
            mem_ready = 1'b1;
        end
        do_reset(nm);
    endtask

    // f = fetch stall cycles, m = data-memory stall cycles
    task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                             input int f, input int m, input logic z, input logic l);
        int L = 2, rf_c = 0, mw_c = 0, pc_c = 0;
        logic memop = 0, hlt = 0, ill = 0, br = 0, tk = 0;
        logic [2:0] imm_e = 0;
        logic [1:0] ctrl3 = 0, a3 = 0, b3 = 0, rs3 = 0;
        case (op)
            7'b0110011: begin L = 4; rf_c = 4; ctrl3 = 2; a3 = 2; end
            7'b0010011: begin L = 4; rf_c = 4; ctrl3 = 2; a3 = 2; b3 = 1; end
            7'b0000011: begin L = 5; rf_c = 5; memop = 1; a3 = 2; b3 = 1; end
            7'b0100011: begin L = 4; mw_c = 4; memop = 1; a3 = 2; b3 = 1; imm_e = 1; end
            7'b1100011: begin
                imm_e = 2;
                if (f3 == 3'd2 || f3 == 3'd3) begin hlt = 1; ill = 1; end
                else begin
                    L = 3; br = 1; ctrl3 = 1; a3 = 2;
                    tk = (f3 == 0) ? z : (f3 == 1) ? !z : (f3 == 4 || f3 == 6) ? l : !l;
                end
            end
            7'b1101111: begin L = 4; pc_c = 3; rf_c = 4; imm_e = 4; a3 = 1; b3 = 2; end
            7'b1100111: begin L = 5; pc_c = 3; rf_c = 5; a3 = 2; b3 = 1; rs3 = 2; end
            7'b0110111: begin L = 4; rf_c = 4; imm_e = 3; a3 = 3; b3 = 1; end
            7'b0010111: begin L = 3; rf_c = 3; imm_e = 3; end
            7'b0001111: L = 2;
            7'b1110011: begin hlt = 1; ill = (f3 != 0); end
            default:    begin hlt = 1; ill = 1; end
        endcase
        for (int j = 1; j <= L; j++) begin
            logic sens;
            int st;
            sens = (j == 1) || (memop && j == 4);
            st = (j == 1) ? f : sens ? m : 0;
            for (int s = 0; s <= st; s++) begin
                logic fin;
                @(negedge clk);
                opcode = op;
                funct3 = f3;
                alu_zero = z;
                alu_lsb = l;
                mem_ready = sens ? (s == st) : 1'($urandom % 2);
                #1;
                fin = (s == st);
                chk($sformatf("%s strobes c%0d.%0d", nm, j, s), strobes(),
                    8'({fin && j == 1, fin && (j == 1 || j == pc_c || (br && j == 3 && tk)),
                        fin && j == mw_c, fin && j == rf_c, fin && j == L && !hlt}));
                chk($sformatf("%s halted c%0d", nm, j), 8'(halted), 8'd0);
                chk($sformatf("%s illegal c%0d", nm, j), 8'(illegal), 8'd0);
                if (j == 2) begin
                    chk({nm, " imm_src"}, 8'(imm_src), 8'(imm_e));
                    chk({nm, " decode a/b"}, 8'({alu_src_a, alu_src_b}), 8'b0101);
                end
                if (j == 3) begin
                    chk({nm, " alu_ctrl c3"}, 8'(alu_ctrl), 8'(ctrl3));
                    chk({nm, " a/b c3"}, 8'({alu_src_a, alu_src_b}), 8'({a3, b3}));
                    chk({nm, " result_src c3"}, 8'(result_src), 8'(rs3));
                end
                if (memop && j == 4) chk({nm, " adr_src"}, 8'(adr_src), 8'd1);
            end
        end
        if (hlt) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                mem_ready = 1'($urandom % 2);
                opcode = 7'($urandom);
                #1;
                chk($sformatf("%s halt strobes %0d", nm, i), strobes(), 8'd0);
                chk($sformatf("%s halted %0d", nm, i), 8'(halted), 8'd1);
                chk($sformatf("%s illegal %0d", nm, i), 8'(illegal), 8'(ill));
            end
            do_reset(nm);
        end
    endtask

    function automatic logic legal_op(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111,
                          7'b1110011};
    endfunction

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic [2:0] brf [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        do_reset("init");
        run_instr("add",    7'b0110011, 3'b000, 0, 0, 1'b0, 1'b0);
        run_instr("lw",     7'b0000011, 3'b010, 3, 2, 1'b0, 1'b0);
        run_instr("sw",     7'b0100011, 3'b010, 0, 0, 1'b0, 1'b0);
        run_instr("bne_z1", 7'b1100011, 3'b001, 0, 0, 1'b1, 1'b0);
        run_instr("bne_z0", 7'b1100011, 3'b001, 0, 0, 1'b0, 1'b0);
        run_instr("bgeu",   7'b1100011, 3'b111, 0, 0, 1'b0, 1'b0);
        run_instr("jalr",   7'b1100111, 3'b000, 0, 0, 1'b0, 1'b0);
        run_instr("jal",    7'b1101111, 3'b000, 0, 0, 1'b0, 1'b0);
        run_instr("lui",    7'b0110111, 3'b000, 0, 0, 1'b0, 1'b0);
        run_instr("auipc",  7'b0010111, 3'b000, 0, 0, 1'b0, 1'b0);
        run_instr("fence",  7'b0001111, 3'b000, 0, 0, 1'b0, 1'b0);
        run_instr("op0",    7'b0000000, 3'b000, 0, 0, 1'b0, 1'b0);
        run_instr("ebreak", 7'b1110011, 3'b000, 0, 0, 1'b0, 1'b0);
        run_instr("sw_stall", 7'b0100011, 3'b000, 1, 3, 1'b0, 1'b0);
        partial("rst_fetch",  7'b0110011, 0);
        partial("rst_memwr",  7'b0100011, 3);
        partial("rst_aluwb",  7'b0110011, 3);
        partial("rst_memrd",  7'b0000011, 3);
        for (int n = 0; n < 80; n++) begin
            f3 = 3'($urandom);
            case ($urandom % 12)
                0: op = 7'b0110011;
                1: op = 7'b0010011;
                2: op = 7'b0000011;
                3: op = 7'b0100011;
                4: begin op = 7'b1100011; f3 = brf[$urandom % 6]; end
                5: op = 7'b1101111;
                6: begin op = 7'b1100111; f3 = 3'b000; end
                7: op = 7'b0110111;
                8: op = 7'b0010111;
                9: op = 7'b0001111;
                10: begin op = 7'b1110011; f3 = 3'b000; end
                default: case ($urandom % 3)
                    0: begin op = 7'b1100011; f3 = 3'd2 + 3'($urandom % 2); end
                    1: begin op = 7'b1110011; f3 = 3'd1 + 3'($urandom % 7); end
                    default: begin
                        op = 7'($urandom);
                        while (legal_op(op)) op = 7'($urandom);
                    end
                endcase
            endcase
            run_instr($sformatf("rnd%0d", n), op, f3, int'($urandom % 4), int'($urandom % 4),
                      1'($urandom % 2), 1'($urandom % 2));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
